// File: rtl/debug_run_ctrl_if.sv
// Debug run controller bus interface.
// Groups the debugger-side controls and the processor/display status lines.
//   stepBtn   raw single-step push-button (async, active-high)
//   runSw     run switch level, 1 = free-run requested
//   bpEnable  breakpoint enable
//   bpLine    breakpoint instruction line (PC >> 2 numbering)
//   pc        current processor PC
//   haltInstr current instruction is program-end / halt
//   cpuEn     processor clock enable, one pulse = one instruction
//   runState  controller state code for display
//   stepCount instructions issued since reset, saturating
//   halted    high once a halt instruction has stopped the core
// master drives the controls (debugger/bench), slave is the controller.
interface debug_run_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             stepBtn;
   logic             runSw;
   logic             bpEnable;
   logic [7:0]       bpLine;
   logic [31:0]      pc;
   logic             haltInstr;
   logic             cpuEn;
   logic [2:0]       runState;
   logic [CNT_W-1:0] stepCount;
   logic             halted;

   modport master (
      output stepBtn, runSw, bpEnable, bpLine, pc, haltInstr,
      input  cpuEn, runState, stepCount, halted
   );

   modport slave (
      input  stepBtn, runSw, bpEnable, bpLine, pc, haltInstr,
      output cpuEn, runState, stepCount, halted
   );
endinterface

// File: rtl/debug_run_ctrl.sv
// Execution controller for the board debugger.
// Gates the processor clock enable: free-run at 1/RUN_DIV rate, single-step from a
// debounced push-button, stop at a breakpoint line, or halt permanently on a halt opcode.
// Ports:
//   Clk  system clock
//   Rst  asynchronous active-low reset
//   bus  debug_run_ctrl_if slave modport (controls in, cpuEn/status out)
module debug_run_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RUN_DIV         = 4,
   parameter int unsigned CNT_W           = 16
) (
   input logic             Clk,
   input logic             Rst,
   debug_run_ctrl_if.slave bus
);

   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);

   typedef enum logic [2:0] {
      StPaused = 3'd0,
      StStep   = 3'd1,
      StRun    = 3'd2,
      StBreak  = 3'd3,
      StHalted = 3'd4
   } state_e;

   state_e           state_q;
   logic             sync1_q, sync2_q;
   logic             level_q, level_prev_q;
   logic             step_req_q;
   logic [DW-1:0]    db_cnt_q;
   logic [PW-1:0]    presc_q;
   logic             cpu_en_q;
   logic [CNT_W-1:0] step_count_q;
   logic [CNT_W-1:0] step_count_inc;
   logic             bp_hit;
   logic             presc_tc;
   logic             unused_pc;

   // Only the line-number field of the PC takes part in the breakpoint compare.
   assign unused_pc = ^{bus.pc[31:10], bus.pc[1:0]};
   assign bp_hit    = bus.bpEnable && (bus.pc[9:2] == bus.bpLine);
   assign presc_tc  = (presc_q == PRESC_LAST);

   always_comb begin
      step_count_inc = step_count_q;
      if (!(&step_count_q)) begin
         step_count_inc = step_count_q + CNT_W'(1);
      end
   end

   // Step button: synchronize, debounce, then a registered rising-edge pulse.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         step_req_q   <= 1'b0;
         db_cnt_q     <= '0;
      end else begin
         sync1_q <= bus.stepBtn;
         sync2_q <= sync1_q;
         if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
               level_q  <= sync2_q;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + DW'(1);
            end
         end else begin
            db_cnt_q <= '0;
         end
         level_prev_q <= level_q;
         step_req_q   <= level_q & ~level_prev_q;
      end
   end

   // Run FSM. cpu_en_q is set on the same edge that counts the instruction, so the
   // enable is a clean registered pulse and stepCount moves with it.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= StPaused;
         presc_q      <= '0;
         cpu_en_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         cpu_en_q <= 1'b0;
         unique case (state_q)
            StPaused: begin
               if (step_req_q) begin
                  state_q      <= StStep;
                  cpu_en_q     <= 1'b1;
                  step_count_q <= step_count_inc;
               end else if (bus.runSw) begin
                  state_q <= StRun;
                  presc_q <= '0;
               end
            end
            StStep: begin
               state_q <= bus.haltInstr ? StHalted : StPaused;
            end
            StRun: begin
               if (bus.haltInstr) begin
                  state_q <= StHalted;
               end else if (!bus.runSw) begin
                  state_q <= StPaused;
                  presc_q <= '0;
               end else if (presc_tc) begin
                  presc_q <= '0;
                  if (bp_hit) begin
                     state_q <= StBreak;
                  end else begin
                     cpu_en_q     <= 1'b1;
                     step_count_q <= step_count_inc;
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            StBreak: begin
               // A step is the only way past the breakpoint line.
               if (step_req_q) begin
                  state_q      <= StStep;
                  cpu_en_q     <= 1'b1;
                  step_count_q <= step_count_inc;
               end else if (!bus.runSw) begin
                  state_q <= StPaused;
               end
            end
            StHalted: begin
               state_q <= StHalted;
            end
            default: begin
               state_q <= StPaused;
            end
         endcase
      end
   end

   assign bus.cpuEn     = cpu_en_q;
   assign bus.runState  = state_q;
   assign bus.stepCount = step_count_q;
   assign bus.halted    = (state_q == StHalted);

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: a vector table for state/pulse behaviour
// plus hand-written sequences for step latency, bounce, free-run, breakpoint, halt,
// counter saturation (narrow-counter instance) and asynchronous reset.
module tb_debug_run_ctrl;

   logic Clk;
   logic Rst;
   int   total;
   int   bad;
   int   pulses0;
   int   pulses1;
   logic prev0;
   bit   pc_auto;

   debug_run_ctrl_if #(.CNT_W(16)) b0 ();
   debug_run_ctrl_if #(.CNT_W(3))  b1 ();

   debug_run_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV        (3),
      .CNT_W          (16)
   ) dut0 (
      .Clk(Clk),
      .Rst(Rst),
      .bus(b0.slave)
   );

   debug_run_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV        (3),
      .CNT_W          (3)
   ) dut1 (
      .Clk(Clk),
      .Rst(Rst),
      .bus(b1.slave)
   );

   typedef struct {
      logic        run_sw;
      logic        bp_en;
      logic [7:0]  bp_line;
      logic [31:0] pc;
      logic        halt;
      int          cycles;
      int          exp_pulses;
      logic [2:0]  exp_state;
      int          exp_count;
   } vec_t;

   vec_t vecs[9];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Advance n cycles, sampling at the falling edge; the bench acts as the processor
   // by advancing pc on each enable pulse when pc_auto is set.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         if (b0.cpuEn) begin
            pulses0++;
            check("no_back_to_back", {31'b0, prev0}, 32'd0);
            if (pc_auto) b0.pc = b0.pc + 32'd4;
         end
         prev0 = b0.cpuEn;
         if (b1.cpuEn) pulses1++;
      end
   endtask

   task automatic clear_inputs();
      b0.stepBtn = 0; b0.runSw = 0; b0.bpEnable = 0; b0.bpLine = 0;
      b0.pc = 0; b0.haltInstr = 0;
      b1.stepBtn = 0; b1.runSw = 0; b1.bpEnable = 0; b1.bpLine = 0;
      b1.pc = 0; b1.haltInstr = 0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      clear_inputs();
      Rst = 1'b0;
      tick(2);
      Rst = 1'b1;
      pulses0 = 0;
      pulses1 = 0;
      prev0   = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] st, input int max_cycles, input string name);
      int n;
      n = 0;
      while (b0.runState !== st && n < max_cycles) begin
         tick(1);
         n++;
      end
      check(name, {29'b0, b0.runState}, {29'b0, st});
   endtask

   initial begin
      int p;
      total   = 0;
      bad     = 0;
      pulses0 = 0;
      pulses1 = 0;
      prev0   = 1'b0;
      pc_auto = 1'b0;

      vecs[0] = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 5, 0, 3'd0, 0};
      vecs[1] = '{1'b1, 1'b1, 8'h05, 32'h0000_0020, 1'b0, 7, 2, 3'd2, 2};
      vecs[2] = '{1'b1, 1'b0, 8'h05, 32'h0000_0014, 1'b0, 3, 1, 3'd2, 3};
      vecs[3] = '{1'b1, 1'b1, 8'h05, 32'h0000_0414, 1'b0, 3, 0, 3'd3, 3};
      vecs[4] = '{1'b1, 1'b0, 8'h05, 32'h0000_0414, 1'b0, 4, 0, 3'd3, 3};
      vecs[5] = '{1'b0, 1'b0, 8'h05, 32'h0000_0414, 1'b0, 1, 0, 3'd0, 3};
      vecs[6] = '{1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 1, 0, 3'd2, 3};
      vecs[7] = '{1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 1, 0, 3'd4, 3};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 3, 0, 3'd4, 3};

      // Reset values while reset is held.
      clear_inputs();
      Rst = 1'b0;
      tick(3);
      check("rst_cpuEn", {31'b0, b0.cpuEn}, 32'd0);
      check("rst_runState", {29'b0, b0.runState}, 32'd0);
      check("rst_stepCount", {16'b0, b0.stepCount}, 32'd0);
      check("rst_halted", {31'b0, b0.halted}, 32'd0);
      Rst = 1'b1;
      tick(2);
      check("post_rst_cpuEn", {31'b0, b0.cpuEn}, 32'd0);

      // Step latency: button high before edge 0, pulse in the cycle after edge 7.
      b0.stepBtn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         check($sformatf("step_cpuEn_k%0d", k), {31'b0, b0.cpuEn}, {31'b0, (k == 7)});
      end
      check("step_count", {16'b0, b0.stepCount}, 32'd1);
      check("step_state", {29'b0, b0.runState}, 32'd0);
      b0.stepBtn = 1'b0;
      tick(10);

      // Bounce shorter than the debounce window.
      p = pulses0;
      for (int r = 0; r < 5; r++) begin
         b0.stepBtn = 1'b1;
         tick(3);
         b0.stepBtn = 1'b0;
         tick(1);
      end
      tick(10);
      check("bounce_pulses", 32'(pulses0 - p), 32'd0);
      check("bounce_count", {16'b0, b0.stepCount}, 32'd1);

      // Free-run with pc advancing per pulse.
      do_reset();
      pc_auto  = 1'b1;
      b0.runSw = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         tick(1);
         check($sformatf("run_cpuEn_k%0d", k), {31'b0, b0.cpuEn},
               {31'b0, (k >= 4 && (k - 4) % 3 == 0)});
      end
      check("run_count", {16'b0, b0.stepCount}, 32'd10);
      check("run_pc", b0.pc, 32'd40);
      b0.runSw = 1'b0;
      tick(1);
      check("run_stop_state", {29'b0, b0.runState}, 32'd0);
      p = pulses0;
      tick(6);
      check("run_stop_pulses", 32'(pulses0 - p), 32'd0);

      // Breakpoint at line 5, then step past it.
      do_reset();
      pc_auto     = 1'b1;
      b0.bpEnable = 1'b1;
      b0.bpLine   = 8'h05;
      b0.runSw    = 1'b1;
      wait_state(3'd3, 40, "bp_reach_break");
      check("bp_pc", b0.pc, 32'h14);
      check("bp_count", {16'b0, b0.stepCount}, 32'd5);
      check("bp_pulses", 32'(pulses0), 32'd5);
      tick(5);
      check("bp_hold_state", {29'b0, b0.runState}, 32'd3);
      b0.stepBtn = 1'b1;
      wait_state(3'd1, 20, "bp_step_state");
      check("bp_step_cpuEn", {31'b0, b0.cpuEn}, 32'd1);
      tick(1);
      check("bp_after_step_state", {29'b0, b0.runState}, 32'd0);
      check("bp_after_step_cpuEn", {31'b0, b0.cpuEn}, 32'd0);
      b0.runSw = 1'b0;
      tick(1);
      b0.stepBtn = 1'b0;
      tick(10);
      check("bp_step_count", {16'b0, b0.stepCount}, 32'd6);
      check("bp_step_pc", b0.pc, 32'h18);
      check("bp_final_state", {29'b0, b0.runState}, 32'd0);

      // Halt in RUN; nothing but reset leaves HALTED.
      do_reset();
      pc_auto  = 1'b1;
      b0.runSw = 1'b1;
      tick(5);
      b0.haltInstr = 1'b1;
      tick(1);
      check("halt_state", {29'b0, b0.runState}, 32'd4);
      check("halt_halted", {31'b0, b0.halted}, 32'd1);
      check("halt_cpuEn", {31'b0, b0.cpuEn}, 32'd0);
      b0.haltInstr = 1'b0;
      p = pulses0;
      b0.runSw = 1'b0;
      tick(3);
      b0.runSw = 1'b1;
      tick(3);
      b0.stepBtn = 1'b1;
      tick(12);
      b0.stepBtn = 1'b0;
      tick(10);
      check("halt_no_pulses", 32'(pulses0 - p), 32'd0);
      check("halt_still_state", {29'b0, b0.runState}, 32'd4);
      check("halt_count", {16'b0, b0.stepCount}, 32'd1);
      do_reset();
      tick(1);
      check("halt_rst_state", {29'b0, b0.runState}, 32'd0);
      check("halt_rst_halted", {31'b0, b0.halted}, 32'd0);

      // Vector table with a static pc.
      do_reset();
      pc_auto = 1'b0;
      for (int v = 0; v < 9; v++) begin
         b0.runSw     = vecs[v].run_sw;
         b0.bpEnable  = vecs[v].bp_en;
         b0.bpLine    = vecs[v].bp_line;
         b0.pc        = vecs[v].pc;
         b0.haltInstr = vecs[v].halt;
         p = pulses0;
         tick(vecs[v].cycles);
         check($sformatf("vec%0d_pulses", v), 32'(pulses0 - p), 32'(vecs[v].exp_pulses));
         check($sformatf("vec%0d_state", v), {29'b0, b0.runState}, {29'b0, vecs[v].exp_state});
         check($sformatf("vec%0d_count", v), {16'b0, b0.stepCount}, 32'(vecs[v].exp_count));
      end

      // Saturation on the 3-bit counter instance.
      do_reset();
      b1.runSw = 1'b1;
      tick(31);
      check("sat_pulses", 32'(pulses1), 32'd10);
      check("sat_count", {29'b0, b1.stepCount}, 32'd7);
      b1.runSw = 1'b0;

      // Asynchronous reset during a pulse, away from any clock edge.
      do_reset();
      pc_auto  = 1'b1;
      b0.runSw = 1'b1;
      tick(7);
      check("mid_pre_cpuEn", {31'b0, b0.cpuEn}, 32'd1);
      check("mid_pre_count", {16'b0, b0.stepCount}, 32'd2);
      #2;
      Rst = 1'b0;
      #1;
      check("mid_rst_cpuEn", {31'b0, b0.cpuEn}, 32'd0);
      check("mid_rst_count", {16'b0, b0.stepCount}, 32'd0);
      check("mid_rst_state", {29'b0, b0.runState}, 32'd0);
      @(negedge Clk);
      prev0 = 1'b0;
      Rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check($sformatf("rel_cpuEn_k%0d", k), {31'b0, b0.cpuEn}, {31'b0, (k == 4)});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
